// File: rtl/pulse_rx_sync_if.sv
// ---------------------------------------------------------------------------
// pulse_rx_sync_if : event inputs and status outputs of the pulse receiver
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pulse_rx_sync_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 4
);
  logic [CH-1:0]       async_in;
  logic [CH-1:0]       mode;
  logic [CH-1:0]       clr;
  logic [CH-1:0]       pulse_out;
  logic [CH-1:0]       level_out;
  logic [CH-1:0]       pending;
  logic [CH-1:0]       ovf;
  logic [CH*CNT_W-1:0] ev_cnt;

  modport master (
    output async_in, mode, clr,
    input  pulse_out, level_out, pending, ovf, ev_cnt
  );

  modport slave (
    input  async_in, mode, clr,
    output pulse_out, level_out, pending, ovf, ev_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pulse_rx_sync.sv
// ---------------------------------------------------------------------------
// pulse_rx_sync : multi-channel CDC event receiver with pulse, sticky and count
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pulse_rx_sync #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  pulse_rx_sync_if.slave  s_if
);

  localparam int                 c_arm_w    = $clog2(SYNC_STAGES + 2);
  localparam logic [c_arm_w-1:0] c_arm_done = c_arm_w'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   c_cnt_max  = '1;

  logic [SYNC_STAGES-1:0][CH-1:0] r_sync;
  logic [CH-1:0]                  r_hist;
  logic [CH-1:0]                  r_pulse;
  logic [CH-1:0]                  r_pend;
  logic [CH-1:0]                  r_ovf;
  logic [CH-1:0][CNT_W-1:0]       r_cnt;
  logic [c_arm_w-1:0]             r_arm_cnt;

  logic                           w_armed;
  logic [CH-1:0]                  w_level;
  logic [CH-1:0]                  w_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= s_if.async_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1];

  // Hold off detection until the chains have flushed the reset zeros, so a
  // static-high input at release is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arm_cnt <= '0;
    end else if (r_arm_cnt != c_arm_done) begin
      r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  assign w_armed = (r_arm_cnt == c_arm_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist  <= '0;
      r_pulse <= '0;
    end else begin
      r_hist  <= w_level;
      r_pulse <= w_ev;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign w_ev[i] = w_armed & (s_if.mode[i] ? (w_level[i] & ~r_hist[i])
                                             : (w_level[i] ^ r_hist[i]));
  end

  // A clear coinciding with an event restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (s_if.clr[i]) begin
          r_cnt[i]  <= w_ev[i] ? CNT_W'(1) : '0;
          r_pend[i] <= w_ev[i];
          r_ovf[i]  <= 1'b0;
        end else if (w_ev[i]) begin
          r_pend[i] <= 1'b1;
          if (r_cnt[i] == c_cnt_max) begin
            r_ovf[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign s_if.pulse_out = r_pulse;
  assign s_if.level_out = w_level;
  assign s_if.pending   = r_pend;
  assign s_if.ovf       = r_ovf;
  assign s_if.ev_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: doc/pulse_rx_sync.md
Name: pulse_rx_sync

Overview:
- Multi-channel receiver for event signals that come from foreign clock domains and are captured in the local clk domain.
- Each channel has a parametrised-depth synchroniser and a per-channel mode: toggle (any edge is an event) or level (rising edge only).
- Produces a one-cycle event pulse, a synchronised level, a sticky pending flag, and a saturating event counter with overflow.
- Sits at the local end of the toggle-encoded event links driven by remote blocks.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, flops in each synchroniser chain (>=2)
CNT_W, 4, width of each per-channel event counter (>=1)

Ports:
clk  input  1  local clock; all logic is on its rising edge
rst  input  1  reset, synchronous and active-high
async_in  input  CH  asynchronous event inputs, one bit per channel, from foreign domains
mode  input  CH  per channel: 0 = toggle mode (any edge is an event), 1 = level mode (rising edge only); quasi-static
clr  input  CH  per-channel one-cycle clear of pending, counter and overflow
pulse_out  output  CH  one-cycle event strobe per channel
level_out  output  CH  synchronised value of async_in (last sync stage)
pending  output  CH  sticky "event seen since last clr"
ovf  output  CH  sticky "counter saturated and a further event arrived"
ev_cnt  output  CH*CNT_W  per-channel event counters; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst high at a clk edge):
  - sync chains, edge-history flop, pulse_out, pending, ovf and ev_cnt all clear to 0.
  - The arm counter clears to 0; events are disarmed.
- Synchroniser:
  - stage0 <= async_in; stage k <= stage k-1.
  - level_out = stage SYNC_STAGES-1.
  - No logic sits between async_in and stage0.
- Edge history: hist <= level_out every cycle.
- Arming, shared by all channels:
  - After rst deasserts, a counter runs for SYNC_STAGES+1 cycles.
  - Until it completes, events are suppressed, but hist and the sync chains keep updating.
  - Consequence: a static high input at reset release never produces an event in either mode.
- Event detection, per channel, only when armed:
  - mode=0: ev = level_out XOR hist.
  - mode=1: ev = level_out AND NOT hist.
- pulse_out:
  - Registered: pulse_out <= ev, high for exactly one cycle per event.
  - Latency: a change sampled into stage0 at edge n gives pulse_out high during the cycle after edge n+SYNC_STAGES.
  - Inputs toggling faster than one change per 2 clk cycles are out of contract; there is no event-loss guarantee.
- Counter, per channel, updated with the same timing as pulse_out:
  - ev and ev_cnt < max: ev_cnt increments by 1.
  - ev and ev_cnt == 2^CNT_W-1: ev_cnt holds and ovf <= 1.
  - pending <= 1 on any ev.
- clr[i], evaluated with the same-cycle ev[i]:
  - clr and no ev: ev_cnt = 0, pending = 0, ovf = 0.
  - clr and ev at the same time: ev_cnt = 1, pending = 1, ovf = 0; the event is never lost.
  - clr has no effect on pulse_out, level_out or the sync chains.
- mode change mid-operation: takes effect on the next detection cycle; no event is generated by the change itself.
- Reset mid-operation: all state clears within the same edge; any in-flight edge in the sync chain is discarded; rearming restarts.
- Channels are fully independent apart from the shared arm counter.

Test Plan:
1. Reset release with async_in=4'b1111, mode=4'b0000, held for 20 cycles -> pulse_out stays 0 throughout; pending=0; ev_cnt=0; level_out=4'b1111 after 2 cycles.
2. Toggle mode: after arming, toggle async_in[0] three times, 6 cycles apart -> three single-cycle pulses on pulse_out[0], each 3 edges after capture; ev_cnt[3:0]=3; pending[0]=1; other channels stay 0.
3. Level mode on ch1 (mode[1]=1): drive 0->1->0->1 -> exactly 2 pulses, on the rising edges only; ev_cnt[7:4]=2.
4. Saturation on ch2: 16 toggle events -> ev_cnt[11:8]=15 after the 15th; the 16th event keeps 15 and sets ovf[2]=1. Then clr[2] pulse alone -> cnt=0, pending[2]=0, ovf[2]=0.
5. clr[3] asserted in the same cycle that ev[3] fires, with cnt previously 5 -> ev_cnt[15:12]=1, pending[3]=1, ovf[3]=0, pulse_out[3]=1.
6. rst asserted 1 cycle after an async_in[0] toggle, then released -> no pulse_out; all counters 0; a later toggle after arming produces a normal pulse.
